stream_mux_rr: RTL and testbench

Parametrised N-input, WIDTH-bit stream multiplexer with valid/ready handshakes, round-robin or fixed-priority arbitration, and a registered output stage. It replaces hard-wired select-driven muxes where several producers compete for one consumer, such as writeback sources or a shared memory port. It delivers one beat per cycle at full throughput, with one cycle of latency.

---
 rtl/stream_mux_rr.sv | 95 +++++++++
 tb/tb_stream_mux_rr.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-way valid/ready stream multiplexer with round-robin
// or fixed-priority arbitration feeding a single registered output stage.
module stream_mux_rr #(
    parameter  int WIDTH = 32,
    parameter  int N     = 3,
    parameter  int MODE  = 0,
    localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] chan [N];
    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  ptr_nxt;
    logic [SELW-1:0]  gsel;
    logic [N-1:0]     grant;
    logic [WIDTH-1:0] gdata;
    logic             found;
    logic             load;
    logic             accept;

    for (genvar i = 0; i < N; i++) begin : g_chan
        assign chan[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Scan starts at ptr in round-robin mode, at 0 in fixed-priority mode.
    always_comb begin : arb
        int              idx;
        logic [SELW-1:0] sel_k;
        grant = '0;
        gsel  = '0;
        gdata = '0;
        found = 1'b0;
        idx   = 0;
        sel_k = '0;
        for (int k = 0; k < N; k++) begin
            if (MODE == 0) begin
                idx = int'(ptr) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
            end else begin
                idx = k;
            end
            sel_k = SELW'(idx);
            if (!found && in_valid[sel_k]) begin
                found        = 1'b1;
                grant[sel_k] = 1'b1;
                gsel         = sel_k;
                gdata        = chan[sel_k];
            end
        end
    end

    // in_ready depends combinationally on out_ready and in_valid.
    assign load     = !out_valid || out_ready;
    assign in_ready = load ? grant : '0;
    assign accept   = load && found;

    always_comb begin
        ptr_nxt = ptr;
        if (MODE == 0) begin
            if (gsel == SELW'(N - 1)) begin
                ptr_nxt = '0;
            end else begin
                ptr_nxt = gsel + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= accept;
            if (accept) begin
                out_data <= gdata;
                out_sel  <= gsel;
                ptr      <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a round-robin and a fixed-priority
// instance share the same stimulus; each task checks its own scenario.
module tb_stream_mux_rr;

    localparam int W = 32;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic           out_ready;

    logic [N-1:0]   rr_in_ready;
    logic           rr_out_valid;
    logic [W-1:0]   rr_out_data;
    logic [1:0]     rr_out_sel;

    logic [N-1:0]   fp_in_ready;
    logic           fp_out_valid;
    logic [W-1:0]   fp_out_data;
    logic [1:0]     fp_out_sel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(W), .N(N), .MODE(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data),
        .in_ready(rr_in_ready),
        .out_valid(rr_out_valid), .out_data(rr_out_data),
        .out_sel(rr_out_sel), .out_ready(out_ready)
    );

    stream_mux_rr #(.WIDTH(W), .N(N), .MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data),
        .in_ready(fp_in_ready),
        .out_valid(fp_out_valid), .out_data(fp_out_data),
        .out_sel(fp_out_sel), .out_ready(out_ready)
    );

    task automatic set_all_data();
        for (int i = 0; i < N; i++) begin
            in_data[i*W +: W] = 32'h100 + i;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        in_valid = 3'b110;
        #1;
        n_checks++;
        if (rr_in_ready !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b want 010", rr_in_ready);
        end
        in_valid = '0;
        rst_n    = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (rr_out_valid !== 1'b0 || rr_out_data !== 32'h0 ||
                rr_out_sel !== 2'd0 || rr_in_ready !== 3'b000) begin
                n_fail++;
                $display("FAIL idle c%0d got v%b d%h s%0d r%b want 0", c,
                         rr_out_valid, rr_out_data, rr_out_sel, rr_in_ready);
            end
        end
    endtask

    task automatic test_single();
        logic [W-1:0] vals [3];
        vals[0] = 32'hA5A5_0001;
        vals[1] = 32'hA5A5_0002;
        vals[2] = 32'hA5A5_0003;
        do_reset();
        in_data = '0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin
                n_checks++;
                if (rr_out_valid !== 1'b1 || rr_out_data !== vals[c-1] ||
                    rr_out_sel !== 2'd1) begin
                    n_fail++;
                    $display("FAIL single c%0d got v%b d%h s%0d want 1 %h 1",
                             c, rr_out_valid, rr_out_data, rr_out_sel,
                             vals[c-1]);
                end
            end
            if (c < 3) begin
                in_valid      = 3'b010;
                in_data[W +: W] = vals[c];
            end else begin
                in_valid = '0;
            end
            @(negedge clk);
        end
        n_checks++;
        if (rr_out_valid !== 1'b0 || rr_out_data !== vals[2]) begin
            n_fail++;
            $display("FAIL single_drain got v%b d%h want 0 %h",
                     rr_out_valid, rr_out_data, vals[2]);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        set_all_data();
        in_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'(c % 3) ||
                rr_out_data !== 32'h100 + 32'(c % 3)) begin
                n_fail++;
                $display("FAIL rr c%0d got v%b s%0d d%h want s%0d", c,
                         rr_out_valid, rr_out_sel, rr_out_data, c % 3);
            end
        end
        in_valid = '0;
    endtask

    task automatic test_fixed_priority();
        do_reset();
        set_all_data();
        in_valid = 3'b111;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if (fp_in_ready !== 3'b001) begin
                n_fail++;
                $display("FAIL fp_ready c%0d got %b want 001", c, fp_in_ready);
            end
            @(negedge clk);
            n_checks++;
            if (fp_out_valid !== 1'b1 || fp_out_sel !== 2'd0 ||
                fp_out_data !== 32'h100) begin
                n_fail++;
                $display("FAIL fp c%0d got v%b s%0d d%h want 1 0 100", c,
                         fp_out_valid, fp_out_sel, fp_out_data);
            end
        end
        in_valid = 3'b110;
        @(negedge clk);
        n_checks++;
        if (fp_out_sel !== 2'd1 || fp_out_data !== 32'h101) begin
            n_fail++;
            $display("FAIL fp_drop got s%0d d%h want 1 101",
                     fp_out_sel, fp_out_data);
        end
        in_valid = '0;
    endtask

    task automatic test_backpressure();
        int exp_sel [3];
        exp_sel[0] = 1;
        exp_sel[1] = 2;
        exp_sel[2] = 0;
        do_reset();
        set_all_data();
        in_valid = 3'b111;
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if (rr_in_ready !== 3'b000) begin
                n_fail++;
                $display("FAIL bp_ready c%0d got %b want 000", c, rr_in_ready);
            end
            @(negedge clk);
            n_checks++;
            if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'd0 ||
                rr_out_data !== 32'h100) begin
                n_fail++;
                $display("FAIL bp_hold c%0d got v%b s%0d d%h want 1 0 100", c,
                         rr_out_valid, rr_out_sel, rr_out_data);
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'(exp_sel[c]) ||
                rr_out_data !== 32'h100 + 32'(exp_sel[c])) begin
                n_fail++;
                $display("FAIL bp_resume c%0d got s%0d d%h want s%0d", c,
                         rr_out_sel, rr_out_data, exp_sel[c]);
            end
        end
        in_valid = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        set_all_data();
        in_valid = 3'b111;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rr_out_valid !== 1'b0 || rr_out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL async_rst got v%b d%h want 0 0",
                     rr_out_valid, rr_out_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'(c)) begin
                n_fail++;
                $display("FAIL async_restart c%0d got v%b s%0d want 1 %0d",
                         c, rr_out_valid, rr_out_sel, c);
            end
        end
        in_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fixed_priority();
        test_backpressure();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
